jtvigil_romarb: RTL and testbench
=================================

# jtvigil_romarb

Three-way ROM fetch arbiter for the Vigilante core: one SDRAM read port is shared among the main CPU program ROM, the sound CPU program ROM and the PCM sample ROM. It sits between the CPU/sample blocks (each using a level `cs`/`ok` handshake) and the SDRAM controller, adds a per-requester base offset, and schedules accesses round-robin. Each requester keeps the last fetched byte until its address changes.

## Interface
Parameters:
- `MAIN_OFFSET`, 22'h00000, SDRAM byte base of main ROM
- `SND_OFFSET`, 22'h30000, SDRAM byte base of sound ROM
- `PCM_OFFSET`, 22'h38000, SDRAM byte base of sample ROM

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `main_cs`  in  1  main CPU requests a byte
- `main_addr`  in  18  main ROM byte address
- `main_data`  out  8  fetched byte
- `main_ok`  out  1  `main_data` valid for current `main_addr`
- `snd_cs`, `snd_addr` [15], `snd_data` [8], `snd_ok`: same roles for the sound CPU
- `pcm_cs`, `pcm_addr` [16], `pcm_data` [8], `pcm_ok`: same roles for the sample player
- `sdram_req`  out  1  read request, level
- `sdram_addr`  out  22  byte address, stable while `sdram_req` high
- `sdram_ack`  in  1  one-cycle pulse: request accepted
- `sdram_rdy`  in  1  one-cycle pulse: `sdram_din` valid
- `sdram_din`  in  8  read data

## Operation
- Per requester x: registers `lat_addr_x`, `data_x`, `valid_x`. `x_ok = valid_x & x_cs & (x_addr == lat_addr_x)`, combinational. `x_data = data_x`.
- Pending: `x_cs & ~(valid_x & x_addr == lat_addr_x)` and x not currently in service.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any pending, grant one by round-robin (order main→snd→pcm, search starts after last granted; after reset last granted = pcm, so main wins first). Latch `lat_addr_x <= x_addr`, clear `valid_x`, load `sdram_addr`, go ISSUE.
  - ISSUE: `sdram_req=1`. On `sdram_ack` go WAIT (drop `sdram_req` same edge).
  - WAIT: on `sdram_rdy` write `data_x <= sdram_din`, `valid_x <= 1`, go IDLE.
- `sdram_addr = OFFSET_x + {zero-ext x_addr}`, truncated to 22 bits.
- Requester changing address during service: fetch completes for the latched address; `x_ok` stays low (compare fails); x becomes pending again and competes in the next IDLE.
- `x_cs` dropped during service: fetch completes and is stored (see Configuration for retention).
- `sdram_rdy` in IDLE/ISSUE, or `sdram_ack` outside ISSUE: ignored.
- Reset: state IDLE, `sdram_req=0`, `sdram_addr=0`, all `valid_x=0`, `data_x=0`, `lat_addr_x=0`, all `x_ok=0`, last-granted = pcm.

## Timing
- Cycle N: pending seen in IDLE. N+1: `sdram_req=1`, address valid. Earliest ack at N+1 → WAIT at N+2. `sdram_rdy` at cycle M → `x_ok=1` at M+1; IDLE at M+1, next grant decision at M+1, next `sdram_req` at M+2.
- Minimum service time: 3 cycles (ack at N+1, rdy at N+2, ok at N+3).
- `x_ok` falls in the same cycle `x_addr` changes or `x_cs` drops (combinational).
- Reset asserted mid-transaction: next edge forces IDLE, `sdram_req` low; a later stale `sdram_rdy` is ignored.
- Simultaneous requests from all three with continuous new addresses: grants rotate main, snd, pcm, main…; no requester waits more than two other services.

## Configuration
- `JTVIGIL_ROMARB_CACHE_EN` defined: `valid_x` retained when `x_cs` drops; reasserting `x_cs` with `x_addr == lat_addr_x` gives `x_ok=1` the same cycle with no SDRAM access.
- Not defined: `valid_x` cleared on any cycle where `x_cs=0` (including a fetch landing while `x_cs=0`); every new assertion of `x_cs` produces an SDRAM access.

## Test plan
- Single main read: `main_addr=18'h08000`, ack/rdy immediate with `sdram_din=8'h5A` → `sdram_addr=22'h08000`, `main_ok=1`, `main_data=8'h5A` 3 cycles after request.
- Offset add: `pcm_addr=16'hFFFF` → `sdram_addr=22'h47FFF`; `snd_addr=15'h0010` → `22'h30010`.
- Round-robin: all three `cs` high at once, each addr changing after each `ok` → grant order main, snd, pcm, main; `sdram_req` never overlaps two grants.
- Address change mid-fetch: main switches 0x100→0x101 while in WAIT → `main_ok` stays 0, second access to 0x101 issued, then `main_ok=1`.
- Reset during WAIT, then `sdram_rdy` pulse → no `valid`, all `ok=0`, `sdram_req=0`.
- Cache: drop and reassert `snd_cs` at same address → with `JTVIGIL_ROMARB_CACHE_EN` `snd_ok=1` immediately, zero `sdram_req`; without it one new SDRAM access.

Source files
------------

// File: rtl/jtvigil_romarb_if.sv
// jtvigil_romarb_if
//   SDRAM read-port bundle shared by the ROM arbiter and the SDRAM controller.
//   req   : read request, level, held until ack
//   addr  : 22-bit byte address, stable while req is high
//   ack   : one-cycle pulse, request accepted
//   rdy   : one-cycle pulse, din carries the read byte
//   din   : 8-bit read data
//   modport master : arbiter side (drives req/addr)
//   modport slave  : SDRAM controller side (drives ack/rdy/din)
interface jtvigil_romarb_if;
  logic        req;
  logic [21:0] addr;
  logic        ack;
  logic        rdy;
  logic [7:0]  din;

  modport master (output req, addr, input ack, rdy, din);
  modport slave  (input req, addr, output ack, rdy, din);
endinterface

// File: rtl/jtvigil_romarb.sv
// jtvigil_romarb
//   Three-way ROM fetch arbiter: main CPU ROM, sound CPU ROM and PCM sample
//   ROM share one SDRAM read port. Each requester uses a level cs/ok
//   handshake; the arbiter adds a per-requester SDRAM base offset and
//   schedules fetches round-robin (main -> snd -> pcm). Each requester keeps
//   its last fetched byte until its address changes.
//
//   Ports
//     clk, rst                     : clock, synchronous active-high reset
//     main_cs/addr[18]/data/ok     : main CPU ROM requester
//     snd_cs/addr[15]/data/ok      : sound CPU ROM requester
//     pcm_cs/addr[16]/data/ok      : PCM sample ROM requester
//     sdram (jtvigil_romarb_if)    : SDRAM read port, master side
//
//   Build option
//     JTVIGIL_ROMARB_CACHE_EN : when defined, a requester's fetched byte stays
//       valid while its cs is low, so reasserting cs at the same address hits
//       without an SDRAM access. When undefined, valid is cleared on every
//       cycle cs is low and each new cs assertion fetches again.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no fetch outstanding; grant the next pending requester
//   ISSUE | sdram.req high with the granted address, waiting for ack
//   WAIT  | request accepted, waiting for the rdy pulse with the data byte
module jtvigil_romarb #(
  parameter logic [21:0] MAIN_OFFSET = 22'h00000,
  parameter logic [21:0] SND_OFFSET  = 22'h30000,
  parameter logic [21:0] PCM_OFFSET  = 22'h38000
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     main_cs,
  input  logic [17:0]              main_addr,
  output logic [7:0]               main_data,
  output logic                     main_ok,

  input  logic                     snd_cs,
  input  logic [14:0]              snd_addr,
  output logic [7:0]               snd_data,
  output logic                     snd_ok,

  input  logic                     pcm_cs,
  input  logic [15:0]              pcm_addr,
  output logic [7:0]               pcm_data,
  output logic                     pcm_ok,

  jtvigil_romarb_if.master         sdram
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic [1:0] {SEL_MAIN, SEL_SND, SEL_PCM} sel_t;

  state_t      state, state_nx;
  sel_t        gnt_q;     // last granted; also the requester in service
  sel_t        gnt_sel;
  logic        gnt_en;
  logic        land;
  logic        req;

  logic [17:0] lat_main;
  logic [14:0] lat_snd;
  logic [15:0] lat_pcm;
  logic [7:0]  data_main, data_snd, data_pcm;

  // bit 0 = main, bit 1 = snd, bit 2 = pcm
  logic [2:0]  valid;
  logic [2:0]  cs_vec;
  logic [2:0]  hit;
  logic [2:0]  pend;
  logic [2:0]  set_v;
  logic [2:0]  clr_v;
  logic [2:0]  drop_v;

  logic [21:0] addr_q;
  logic [21:0] addr_nx;

  assign cs_vec = {pcm_cs, snd_cs, main_cs};

  assign hit[0] = valid[0] & (main_addr == lat_main);
  assign hit[1] = valid[1] & (snd_addr  == lat_snd);
  assign hit[2] = valid[2] & (pcm_addr  == lat_pcm);

  // Pending is only acted on in IDLE, where nobody is in service.
  assign pend = cs_vec & ~hit;

  assign main_ok   = hit[0] & main_cs;
  assign snd_ok    = hit[1] & snd_cs;
  assign pcm_ok    = hit[2] & pcm_cs;
  assign main_data = data_main;
  assign snd_data  = data_snd;
  assign pcm_data  = data_pcm;

  assign sdram.req  = req;
  assign sdram.addr = addr_q;

`ifdef JTVIGIL_ROMARB_CACHE_EN
  assign drop_v = 3'b000;
`else
  // Dropping cs forgets the byte, even one landing in that same cycle.
  assign drop_v = ~cs_vec;
`endif

  // Round-robin pick: search starts with the requester after the last grant.
  always_comb begin
    gnt_sel = SEL_MAIN;
    case (gnt_q)
      SEL_MAIN: begin
        if      (pend[1]) gnt_sel = SEL_SND;
        else if (pend[2]) gnt_sel = SEL_PCM;
        else              gnt_sel = SEL_MAIN;
      end
      SEL_SND: begin
        if      (pend[2]) gnt_sel = SEL_PCM;
        else if (pend[0]) gnt_sel = SEL_MAIN;
        else              gnt_sel = SEL_SND;
      end
      default: begin
        if      (pend[0]) gnt_sel = SEL_MAIN;
        else if (pend[1]) gnt_sel = SEL_SND;
        else              gnt_sel = SEL_PCM;
      end
    endcase
  end

  // Offset add, truncated to the 22-bit SDRAM byte space.
  always_comb begin
    addr_nx = PCM_OFFSET + {6'd0, pcm_addr};
    case (gnt_sel)
      SEL_MAIN: addr_nx = MAIN_OFFSET + {4'd0, main_addr};
      SEL_SND:  addr_nx = SND_OFFSET  + {7'd0, snd_addr};
      default:  addr_nx = PCM_OFFSET  + {6'd0, pcm_addr};
    endcase
  end

  // Next state and FSM outputs.
  always_comb begin
    state_nx = state;
    gnt_en   = 1'b0;
    req      = 1'b0;
    land     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          gnt_en   = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        req = 1'b1;
        if (sdram.ack) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (sdram.rdy) begin
          land     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // One-hot valid set (fetch lands) and clear (new grant) strobes.
  always_comb begin
    set_v = 3'b000;
    clr_v = 3'b000;
    if (land) begin
      case (gnt_q)
        SEL_MAIN: set_v = 3'b001;
        SEL_SND:  set_v = 3'b010;
        default:  set_v = 3'b100;
      endcase
    end
    if (gnt_en) begin
      case (gnt_sel)
        SEL_MAIN: clr_v = 3'b001;
        SEL_SND:  clr_v = 3'b010;
        default:  clr_v = 3'b100;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= SEL_PCM;
      addr_q    <= 22'd0;
      valid     <= 3'b000;
      lat_main  <= 18'd0;
      lat_snd   <= 15'd0;
      lat_pcm   <= 16'd0;
      data_main <= 8'd0;
      data_snd  <= 8'd0;
      data_pcm  <= 8'd0;
    end else begin
      valid <= (valid | set_v) & ~(clr_v | drop_v);
      if (gnt_en) begin
        gnt_q  <= gnt_sel;
        addr_q <= addr_nx;
        case (gnt_sel)
          SEL_MAIN: lat_main <= main_addr;
          SEL_SND:  lat_snd  <= snd_addr;
          default:  lat_pcm  <= pcm_addr;
        endcase
      end
      if (land) begin
        case (gnt_q)
          SEL_MAIN: data_main <= sdram.din;
          SEL_SND:  data_snd  <= sdram.din;
          default:  data_pcm  <= sdram.din;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtvigil_romarb.sv
// tb_jtvigil_romarb
//   Directed bench for jtvigil_romarb. Stimulus pushes the expected SDRAM
//   request addresses and expected ok/data events into queues; a monitor
//   pops and compares them as the DUT raises sdram.req or an x_ok. A small
//   SDRAM responder supplies ack/rdy with programmable delays; its data is
//   a fixed function of the address, and the expected bytes below were
//   worked out by hand from that function.
module tb_jtvigil_romarb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        main_cs = 1'b0;
  logic [17:0] main_addr = '0;
  logic [7:0]  main_data;
  logic        main_ok;
  logic        snd_cs = 1'b0;
  logic [14:0] snd_addr = '0;
  logic [7:0]  snd_data;
  logic        snd_ok;
  logic        pcm_cs = 1'b0;
  logic [15:0] pcm_addr = '0;
  logic [7:0]  pcm_data;
  logic        pcm_ok;

  jtvigil_romarb_if sdram_if ();

  jtvigil_romarb dut (
    .clk       (clk),
    .rst       (rst),
    .main_cs   (main_cs),
    .main_addr (main_addr),
    .main_data (main_data),
    .main_ok   (main_ok),
    .snd_cs    (snd_cs),
    .snd_addr  (snd_addr),
    .snd_data  (snd_data),
    .snd_ok    (snd_ok),
    .pcm_cs    (pcm_cs),
    .pcm_addr  (pcm_addr),
    .pcm_data  (pcm_data),
    .pcm_ok    (pcm_ok),
    .sdram     (sdram_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } okexp_t;

  logic [21:0] exp_addr_q[$];
  okexp_t      exp_ok_q[$];

  int vecs = 0;
  int errs = 0;
  int req_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ok(input logic [1:0] id, input logic [7:0] d);
    okexp_t e;
    e.id   = id;
    e.data = d;
    exp_ok_q.push_back(e);
  endtask

  // ---------------- SDRAM responder ----------------
  int          ack_dly = 0;
  int          rdy_dly = 0;
  int          sd_phase = 0;
  int          sd_cnt = 0;
  logic [21:0] sd_a = '0;

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hDA;
  endfunction

  initial begin
    sdram_if.ack = 1'b0;
    sdram_if.rdy = 1'b0;
    sdram_if.din = 8'h00;
    forever begin
      @(posedge clk); #1;
      sdram_if.ack = 1'b0;
      sdram_if.rdy = 1'b0;
      if (sd_phase == 0) begin
        if (sdram_if.req === 1'b1) begin
          if (sd_cnt >= ack_dly) begin
            sdram_if.ack = 1'b1;
            sd_a     = sdram_if.addr;
            sd_phase = 1;
            sd_cnt   = 0;
          end else sd_cnt++;
        end else sd_cnt = 0;
      end else begin
        if (sd_cnt >= rdy_dly) begin
          sdram_if.rdy = 1'b1;
          sdram_if.din = mem_byte(sd_a);
          sd_phase = 0;
          sd_cnt   = 0;
        end else sd_cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  logic       req_prev = 1'b0;
  logic [2:0] ok_prev = 3'b000;
  logic [2:0] ok_now;
  okexp_t     mon_e;

  function automatic logic [7:0] data_of(input int i);
    case (i)
      0:       return main_data;
      1:       return snd_data;
      default: return pcm_data;
    endcase
  endfunction

  always @(negedge clk) begin
    if (sdram_if.req === 1'b1 && req_prev !== 1'b1) begin
      req_count++;
      if (exp_addr_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_req: got sdram_addr %0h, expected no request", sdram_if.addr);
      end else begin
        check("sdram_addr", {10'd0, sdram_if.addr}, {10'd0, exp_addr_q.pop_front()});
      end
    end
    req_prev = sdram_if.req;

    ok_now = {pcm_ok, snd_ok, main_ok};
    for (int i = 0; i < 3; i++) begin
      if (ok_now[i] === 1'b1 && ok_prev[i] !== 1'b1) begin
        if (exp_ok_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_ok: got ok rise from requester %0d, expected none", i);
        end else begin
          mon_e = exp_ok_q.pop_front();
          check("ok_requester", i, {30'd0, mon_e.id});
          check("ok_data", {24'd0, data_of(i)}, {24'd0, mon_e.data});
        end
      end
    end
    ok_prev = ok_now;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sdram_if.ack !== 1'b1 && n < 50);
    check(name, {31'd0, sdram_if.ack}, 32'd1);
  endtask

  function automatic logic ok_of(input int i);
    case (i)
      0:       return main_ok;
      1:       return snd_ok;
      default: return pcm_ok;
    endcase
  endfunction

  task automatic wait_ok(input int i, input string name);
    int n;
    n = 0;
    while (ok_of(i) !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check(name, {31'd0, ok_of(i)}, 32'd1);
  endtask

  // let the monitor see the last ok, then release all requesters
  task automatic settle();
    @(negedge clk);
    step();
    main_cs = 1'b0;
    snd_cs  = 1'b0;
    pcm_cs  = 1'b0;
    repeat (2) step();
  endtask

  // ---------------- directed sequence ----------------
  int         cyc;
  int         rc0;
  int         idx[3];
  logic [2:0] okv;

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) step();
    main_cs = 1'b1; snd_cs = 1'b1; pcm_cs = 1'b1;
    #1;
    check("rst_main_ok", {31'd0, main_ok}, 32'd0);
    check("rst_snd_ok",  {31'd0, snd_ok},  32'd0);
    check("rst_pcm_ok",  {31'd0, pcm_ok},  32'd0);
    check("rst_req",     {31'd0, sdram_if.req}, 32'd0);
    check("rst_addr",    {10'd0, sdram_if.addr}, 32'd0);
    check("rst_data",    {8'd0, main_data, snd_data, pcm_data}, 32'd0);
    main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
    step();
    rst = 1'b0;
    step();

    // round-robin: all three at once, each moves to a new address after ok
    exp_addr_q.push_back(22'h000123); expect_ok(2'd0, 8'hF8);
    exp_addr_q.push_back(22'h030010); expect_ok(2'd1, 8'hC9);
    exp_addr_q.push_back(22'h047FFF); expect_ok(2'd2, 8'h5E);
    exp_addr_q.push_back(22'h03FFFF); expect_ok(2'd0, 8'hD9);
    exp_addr_q.push_back(22'h037FFF); expect_ok(2'd1, 8'h59);
    exp_addr_q.push_back(22'h038000); expect_ok(2'd2, 8'h59);
    rc0 = req_count;
    main_addr = 18'h00123; snd_addr = 15'h0010; pcm_addr = 16'hFFFF;
    main_cs = 1'b1; snd_cs = 1'b1; pcm_cs = 1'b1;
    idx[0] = 0; idx[1] = 0; idx[2] = 0;
    cyc = 0;
    while (!(idx[0] == 2 && idx[1] == 2 && idx[2] == 2) && cyc < 200) begin
      @(negedge clk);
      okv = {pcm_ok, snd_ok, main_ok};
      step();
      cyc++;
      if (okv[0] === 1'b1) begin
        idx[0]++;
        if (idx[0] == 1) main_addr = 18'h3FFFF; else main_cs = 1'b0;
      end
      if (okv[1] === 1'b1) begin
        idx[1]++;
        if (idx[1] == 1) snd_addr = 15'h7FFF; else snd_cs = 1'b0;
      end
      if (okv[2] === 1'b1) begin
        idx[2]++;
        if (idx[2] == 1) pcm_addr = 16'h0000; else pcm_cs = 1'b0;
      end
    end
    check("rr_req_count", req_count - rc0, 32'd6);
    settle();

    // single main read, immediate ack/rdy: ok three cycles after request
    exp_addr_q.push_back(22'h008000); expect_ok(2'd0, 8'h5A);
    main_addr = 18'h08000;
    main_cs   = 1'b1;
    cyc = 0;
    while (main_ok !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    check("main_latency", cyc, 32'd3);
    check("main_data_direct", {24'd0, main_data}, 32'h5A);
    settle();

    // address change while the fetch is in WAIT
    rdy_dly = 3;
    exp_addr_q.push_back(22'h000100);
    exp_addr_q.push_back(22'h000101); expect_ok(2'd0, 8'hDA);
    main_addr = 18'h00100;
    main_cs   = 1'b1;
    wait_ack("chg_first_ack");
    step();
    main_addr = 18'h00101;
    rc0 = req_count;
    wait_ok(0, "chg_ok");
    check("chg_req_count", req_count - rc0, 32'd1);
    settle();

    // reset during WAIT, followed by a stale rdy
    rdy_dly = 5;
    exp_addr_q.push_back(22'h000200);
    main_addr = 18'h00200;
    main_cs   = 1'b1;
    wait_ack("rst_mid_ack");
    step();
    rst     = 1'b1;
    main_cs = 1'b0;
    step();
    rst = 1'b0;
    check("rst_mid_req", {31'd0, sdram_if.req}, 32'd0);
    check("rst_mid_addr", {10'd0, sdram_if.addr}, 32'd0);
    rc0 = req_count;
    repeat (8) step();
    check("rst_stale_no_req", req_count - rc0, 32'd0);
    rdy_dly = 0;
    exp_addr_q.push_back(22'h000200); expect_ok(2'd0, 8'hD8);
    main_cs = 1'b1;
    #1;
    check("rst_stale_no_valid", {31'd0, main_ok}, 32'd0);
    wait_ok(0, "rst_refetch_ok");
    settle();

    // drop and reassert snd_cs at the same address
    exp_addr_q.push_back(22'h030010); expect_ok(2'd1, 8'hC9);
    snd_addr = 15'h0010;
    snd_cs   = 1'b1;
    wait_ok(1, "cache_first_ok");
    @(negedge clk);
    step();
    snd_cs = 1'b0;
    repeat (2) step();
    rc0 = req_count;
`ifdef JTVIGIL_ROMARB_CACHE_EN
    expect_ok(2'd1, 8'hC9);
`else
    exp_addr_q.push_back(22'h030010); expect_ok(2'd1, 8'hC9);
`endif
    snd_cs = 1'b1;
    #1;
`ifdef JTVIGIL_ROMARB_CACHE_EN
    check("cache_hit_ok", {31'd0, snd_ok}, 32'd1);
`else
    check("cache_hit_ok", {31'd0, snd_ok}, 32'd0);
`endif
    repeat (8) step();
`ifdef JTVIGIL_ROMARB_CACHE_EN
    check("cache_req_count", req_count - rc0, 32'd0);
`else
    check("cache_req_count", req_count - rc0, 32'd1);
`endif
    check("cache_ok_final", {31'd0, snd_ok}, 32'd1);
    settle();

    repeat (4) step();
    check("addr_queue_drained", exp_addr_q.size(), 32'd0);
    check("ok_queue_drained", exp_ok_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
